// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one burst memory port between I-cache refills and
// D-cache refill/write-back, with saturating per-requester grant counters.
module mem_arbiter #(
    parameter int          c_block_size    = 2,
    parameter int          c_line_size     = 32,
    parameter int          address_size    = 32,
    parameter logic [15:0] c_grant_cnt_max = 16'hFFFF
) (
    input  logic                                          m_clk_i,
    input  logic                                          m_reset_i,
    input  logic                                          i_read_i,
    input  logic [address_size-c_block_size-3:0]          i_addr_i,
    output logic [(2**c_block_size)*c_line_size-1:0]      i_rdata_o,
    output logic                                          i_busywait_o,
    output logic                                          i_done_o,
    input  logic                                          d_read_i,
    input  logic                                          d_write_i,
    input  logic [address_size-c_block_size-3:0]          d_addr_i,
    input  logic [(2**c_block_size)*c_line_size-1:0]      d_wdata_i,
    output logic [(2**c_block_size)*c_line_size-1:0]      d_rdata_o,
    output logic                                          d_busywait_o,
    output logic                                          d_done_o,
    output logic                                          mem_read_o,
    output logic                                          mem_write_o,
    output logic [address_size-c_block_size-3:0]          mem_addr_o,
    output logic [(2**c_block_size)*c_line_size-1:0]      mem_wdata_o,
    input  logic [(2**c_block_size)*c_line_size-1:0]      mem_rdata_i,
    input  logic                                          mem_busywait_i,
    input  logic                                          mem_done_i,
    output logic [15:0]                                   i_grant_cnt_o,
    output logic [15:0]                                   d_grant_cnt_o
);

    typedef enum logic [2:0] {IDLE, SERVE_I, SERVE_D, RESP_I, RESP_D} state_t;

    state_t state, state_next;
    logic   grant_i, grant_d;
    logic   d_req;
    logic   last_grant_d;
    logic   op_write;
    logic   unused_mem_busywait;

    assign d_req               = d_read_i | d_write_i;
    assign unused_mem_busywait = mem_busywait_i;

    always_ff @(posedge m_clk_i or posedge m_reset_i) begin
        if (m_reset_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // On contention the requester that did not win last time gets the port.
    always_comb begin
        state_next = state;
        grant_i    = 1'b0;
        grant_d    = 1'b0;
        case (state)
            IDLE: begin
                if (i_read_i && d_req) begin
                    grant_i = last_grant_d;
                    grant_d = ~last_grant_d;
                end else begin
                    grant_i = i_read_i;
                    grant_d = d_req;
                end
                if (grant_i) begin
                    state_next = SERVE_I;
                end else if (grant_d) begin
                    state_next = SERVE_D;
                end
            end
            SERVE_I: if (mem_done_i) state_next = RESP_I;
            SERVE_D: if (mem_done_i) state_next = RESP_D;
            RESP_I:  state_next = IDLE;
            RESP_D:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge m_clk_i or posedge m_reset_i) begin
        if (m_reset_i) begin
            mem_addr_o   <= '0;
            mem_wdata_o  <= '0;
            op_write     <= 1'b0;
            last_grant_d <= 1'b0;
        end else if (grant_i) begin
            mem_addr_o   <= i_addr_i;
            op_write     <= 1'b0;
            last_grant_d <= 1'b0;
        end else if (grant_d) begin
            mem_addr_o   <= d_addr_i;
            mem_wdata_o  <= d_wdata_i;
            op_write     <= d_write_i;
            last_grant_d <= 1'b1;
        end
    end

    // Counters stick at the ceiling instead of wrapping.
    always_ff @(posedge m_clk_i or posedge m_reset_i) begin
        if (m_reset_i) begin
            i_grant_cnt_o <= '0;
            d_grant_cnt_o <= '0;
        end else begin
            if (grant_i && (i_grant_cnt_o < c_grant_cnt_max)) begin
                i_grant_cnt_o <= i_grant_cnt_o + 16'd1;
            end
            if (grant_d && (d_grant_cnt_o < c_grant_cnt_max)) begin
                d_grant_cnt_o <= d_grant_cnt_o + 16'd1;
            end
        end
    end

    always_ff @(posedge m_clk_i or posedge m_reset_i) begin
        if (m_reset_i) begin
            i_rdata_o <= '0;
            d_rdata_o <= '0;
        end else begin
            if ((state == SERVE_I) && mem_done_i) begin
                i_rdata_o <= mem_rdata_i;
            end
            if ((state == SERVE_D) && mem_done_i && !op_write) begin
                d_rdata_o <= mem_rdata_i;
            end
        end
    end

    assign mem_read_o   = (state == SERVE_I) || ((state == SERVE_D) && !op_write);
    assign mem_write_o  = (state == SERVE_D) && op_write;
    assign i_done_o     = (state == RESP_I);
    assign d_done_o     = (state == RESP_D);
    assign i_busywait_o = i_read_i & ~i_done_o;
    assign d_busywait_o = d_req & ~d_done_o;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: transaction-level model compared every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_mem_arbiter;

    localparam int AW      = 28;
    localparam int BW      = 128;
    localparam int SAT     = 5;
    localparam int MEM_LAT = 4;

    logic          m_clk_i = 1'b0;
    logic          m_reset_i = 1'b0;
    logic          i_read_i = 1'b0;
    logic [AW-1:0] i_addr_i = '0;
    logic [BW-1:0] i_rdata_o;
    logic          i_busywait_o, i_done_o;
    logic          d_read_i = 1'b0, d_write_i = 1'b0;
    logic [AW-1:0] d_addr_i = '0;
    logic [BW-1:0] d_wdata_i = '0;
    logic [BW-1:0] d_rdata_o;
    logic          d_busywait_o, d_done_o;
    logic          mem_read_o, mem_write_o;
    logic [AW-1:0] mem_addr_o;
    logic [BW-1:0] mem_wdata_o;
    logic [BW-1:0] mem_rdata_i = '0;
    logic          mem_busywait_i = 1'b0;
    logic          mem_done_i = 1'b0;
    logic [15:0]   i_grant_cnt_o, d_grant_cnt_o;

    int total = 0;
    int bad = 0;
    int mem_cnt = 0;
    logic stray_pulse = 1'b0;
    int rd_cycles = 0, i_done_cnt = 0, d_done_cnt = 0;
    string done_log = "";

    mem_arbiter #(.c_grant_cnt_max(16'd5)) dut (
        .m_clk_i(m_clk_i), .m_reset_i(m_reset_i),
        .i_read_i(i_read_i), .i_addr_i(i_addr_i), .i_rdata_o(i_rdata_o),
        .i_busywait_o(i_busywait_o), .i_done_o(i_done_o),
        .d_read_i(d_read_i), .d_write_i(d_write_i), .d_addr_i(d_addr_i),
        .d_wdata_i(d_wdata_i), .d_rdata_o(d_rdata_o),
        .d_busywait_o(d_busywait_o), .d_done_o(d_done_o),
        .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i), .mem_busywait_i(mem_busywait_i),
        .mem_done_i(mem_done_i),
        .i_grant_cnt_o(i_grant_cnt_o), .d_grant_cnt_o(d_grant_cnt_o)
    );

    always #5 m_clk_i = ~m_clk_i;

    function automatic logic [BW-1:0] mem_pattern(input logic [AW-1:0] a);
        return {32'h44443333, 32'h22221111, 4'h0, a, 32'h89ABCDEF};
    endfunction

    task automatic checkOutput(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory: answers MEM_LAT cycles after a request appears; stray pulses on demand.
    always @(negedge m_clk_i or posedge m_reset_i) begin
        if (m_reset_i) begin
            mem_done_i <= 1'b0;
            mem_cnt    <= 0;
        end else if (mem_done_i) begin
            mem_done_i <= 1'b0;
            mem_cnt    <= 0;
        end else if (stray_pulse) begin
            mem_done_i <= 1'b1;
        end else if (mem_read_o || mem_write_o) begin
            if (mem_cnt == MEM_LAT - 1) begin
                mem_done_i  <= 1'b1;
                mem_rdata_i <= mem_pattern(mem_addr_o);
            end
            mem_cnt <= mem_cnt + 1;
        end
    end

    // Transaction-level model: who owns the port, is it in flight or answering.
    int            m_who;
    logic          m_busy, m_resp, m_wr, m_last_d;
    logic [AW-1:0] m_addr;
    logic [BW-1:0] m_wdata, m_irdata, m_drdata;
    int            m_icnt, m_dcnt;

    function automatic int pick(input logic ireq, input logic dreq, input logic last_d);
        if (ireq && dreq) return last_d ? 1 : 2;
        if (ireq) return 1;
        if (dreq) return 2;
        return 0;
    endfunction

    always @(posedge m_clk_i or posedge m_reset_i) begin
        if (m_reset_i) begin
            m_who <= 0; m_busy <= 1'b0; m_resp <= 1'b0; m_wr <= 1'b0; m_last_d <= 1'b0;
            m_addr <= '0; m_wdata <= '0; m_irdata <= '0; m_drdata <= '0;
            m_icnt <= 0; m_dcnt <= 0;
        end else if (m_resp) begin
            m_resp <= 1'b0;
        end else if (m_busy) begin
            if (mem_done_i) begin
                m_busy <= 1'b0;
                m_resp <= 1'b1;
                if (m_who == 1) m_irdata <= mem_rdata_i;
                else if (!m_wr) m_drdata <= mem_rdata_i;
            end
        end else if (pick(i_read_i, d_read_i | d_write_i, m_last_d) == 1) begin
            m_who <= 1; m_busy <= 1'b1; m_wr <= 1'b0; m_addr <= i_addr_i; m_last_d <= 1'b0;
            m_icnt <= (m_icnt < SAT) ? m_icnt + 1 : SAT;
        end else if (pick(i_read_i, d_read_i | d_write_i, m_last_d) == 2) begin
            m_who <= 2; m_busy <= 1'b1; m_wr <= d_write_i; m_addr <= d_addr_i;
            m_wdata <= d_wdata_i; m_last_d <= 1'b1;
            m_dcnt <= (m_dcnt < SAT) ? m_dcnt + 1 : SAT;
        end
    end

    logic exp_rd, exp_wr, exp_idone, exp_ddone;
    assign exp_rd    = m_busy && ((m_who == 1) || !m_wr);
    assign exp_wr    = m_busy && (m_who == 2) && m_wr;
    assign exp_idone = m_resp && (m_who == 1);
    assign exp_ddone = m_resp && (m_who == 2);

    always @(negedge m_clk_i) begin
        checkOutput("mem_read", mem_read_o, exp_rd);
        checkOutput("mem_write", mem_write_o, exp_wr);
        checkOutput("mem_addr", mem_addr_o, m_addr);
        if (exp_wr) checkOutput("mem_wdata", mem_wdata_o, m_wdata);
        checkOutput("i_done", i_done_o, exp_idone);
        checkOutput("d_done", d_done_o, exp_ddone);
        checkOutput("i_busywait", i_busywait_o, i_read_i & ~exp_idone);
        checkOutput("d_busywait", d_busywait_o, (d_read_i | d_write_i) & ~exp_ddone);
        checkOutput("i_rdata", i_rdata_o, m_irdata);
        checkOutput("d_rdata", d_rdata_o, m_drdata);
        checkOutput("i_cnt", i_grant_cnt_o, m_icnt[15:0]);
        checkOutput("d_cnt", d_grant_cnt_o, m_dcnt[15:0]);
        if (mem_read_o) rd_cycles <= rd_cycles + 1;
        if (i_done_o) i_done_cnt <= i_done_cnt + 1;
        if (d_done_o) d_done_cnt <= d_done_cnt + 1;
    end

    task automatic resetDut();
        m_reset_i = 1'b1;
        i_read_i = 1'b0; d_read_i = 1'b0; d_write_i = 1'b0;
        repeat (2) @(posedge m_clk_i);
        #1 m_reset_i = 1'b0;
        done_log = "";
    endtask

    task automatic applyStimulus(input logic ir, input logic [AW-1:0] ia, input logic dr,
                                 input logic dw, input logic [AW-1:0] da, input logic [BW-1:0] dwd);
        i_read_i = ir; i_addr_i = ia;
        d_read_i = dr; d_write_i = dw; d_addr_i = da; d_wdata_i = dwd;
    endtask

    // Runs until every pending request has completed; each requester drops on the edge ending its done.
    task automatic serveAll(input int budget);
        int   n = 0;
        logic di, dd;
        while ((i_read_i || d_read_i || d_write_i) && (n < budget)) begin
            @(negedge m_clk_i);
            di = i_done_o; dd = d_done_o;
            if (di) done_log = {done_log, "I"};
            if (dd) done_log = {done_log, "D"};
            @(posedge m_clk_i);
            #1;
            if (di) i_read_i = 1'b0;
            if (dd) begin d_read_i = 1'b0; d_write_i = 1'b0; end
            n++;
        end
        checkOutput("serve_timeout", n >= budget, 1'b0);
        i_read_i = 1'b0; d_read_i = 1'b0; d_write_i = 1'b0;
    endtask

    task automatic waitDoneD(input int budget);
        int n = 0;
        do begin
            @(negedge m_clk_i);
            n++;
        end while (!d_done_o && (n < budget));
        checkOutput("d_done_timeout", d_done_o, 1'b1);
    endtask

    localparam logic [BW-1:0] PAT_A = 128'hA0A1A2A3_B0B1B2B3_C0C1C2C3_D0D1D2D3;

    initial begin
        int rd0, id0, dd0;
        resetDut();

        // Reset during a D write aborts it and restores contention priority to D.
        applyStimulus(1'b0, '0, 1'b0, 1'b1, 28'h77, PAT_A);
        repeat (2) @(posedge m_clk_i);
        #1 checkOutput("rst_write_before", mem_write_o, 1'b1);
        m_reset_i = 1'b1; d_write_i = 1'b0;
        #1 checkOutput("rst_write_dropped", mem_write_o, 1'b0);
        repeat (2) @(posedge m_clk_i);
        #1 m_reset_i = 1'b0;
        @(negedge m_clk_i);
        checkOutput("rst_icnt", i_grant_cnt_o, 16'd0);
        checkOutput("rst_dcnt", d_grant_cnt_o, 16'd0);
        checkOutput("rst_addr", mem_addr_o, '0);
        @(posedge m_clk_i);
        #1 applyStimulus(1'b1, 28'h11, 1'b1, 1'b0, 28'h22, '0);
        serveAll(40);
        checkOutput("rst_order_DI", done_log == "DI", 1'b1);

        // Lone I read.
        resetDut();
        rd0 = rd_cycles; id0 = i_done_cnt;
        applyStimulus(1'b1, 28'h10, 1'b0, 1'b0, '0, '0);
        serveAll(40);
        checkOutput("loneI_rdata", i_rdata_o, 128'h44443333_22221111_00000010_89ABCDEF);
        checkOutput("loneI_cnt", i_grant_cnt_o, 16'd1);
        checkOutput("loneI_rd_cycles", rd_cycles - rd0, 4);
        checkOutput("loneI_done_pulses", i_done_cnt - id0, 1);
        checkOutput("loneI_d_rdata", d_rdata_o, '0);

        // Round-robin alternation under repeated contention.
        resetDut();
        applyStimulus(1'b1, 28'h1, 1'b1, 1'b0, 28'h2, '0);
        serveAll(40);
        applyStimulus(1'b1, 28'h3, 1'b1, 1'b0, 28'h4, '0);
        serveAll(40);
        checkOutput("rr_order_DIDI", done_log == "DIDI", 1'b1);
        checkOutput("rr_icnt", i_grant_cnt_o, 16'd2);
        checkOutput("rr_dcnt", d_grant_cnt_o, 16'd2);

        // D write while I waits; I gets the port two cycles after d_done.
        resetDut();
        applyStimulus(1'b1, 28'h50, 1'b0, 1'b1, 28'h20, PAT_A);
        @(posedge m_clk_i);
        @(negedge m_clk_i);
        checkOutput("wr_mem_write", mem_write_o, 1'b1);
        checkOutput("wr_wdata", mem_wdata_o, PAT_A);
        checkOutput("wr_addr", mem_addr_o, 28'h20);
        waitDoneD(20);
        @(posedge m_clk_i);
        #1 d_write_i = 1'b0;
        @(negedge m_clk_i);
        checkOutput("wr_gap_idle", mem_read_o, 1'b0);
        @(negedge m_clk_i);
        checkOutput("wr_i_granted", mem_read_o, 1'b1);
        checkOutput("wr_i_addr", mem_addr_o, 28'h50);
        checkOutput("wr_d_rdata", d_rdata_o, '0);
        serveAll(40);

        // Address change during service is ignored; stray completion in IDLE is ignored.
        resetDut();
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 28'h30, '0);
        repeat (2) @(posedge m_clk_i);
        #1 d_addr_i = 28'h99;
        @(negedge m_clk_i);
        checkOutput("chg_addr_latched", mem_addr_o, 28'h30);
        serveAll(40);
        id0 = i_done_cnt; dd0 = d_done_cnt;
        stray_pulse = 1'b1;
        @(posedge m_clk_i);
        #1 stray_pulse = 1'b0;
        repeat (3) @(posedge m_clk_i);
        #1;
        checkOutput("stray_no_done", (i_done_cnt - id0) + (d_done_cnt - dd0), 0);
        checkOutput("stray_d_rdata", d_rdata_o, mem_pattern(28'h30));

        // Grant counter saturation (ceiling lowered to SAT for a short run).
        resetDut();
        for (int k = 0; k < SAT + 2; k++) begin
            applyStimulus(1'b1, AW'(k), 1'b0, 1'b0, '0, '0);
            serveAll(40);
        end
        checkOutput("sat_icnt", i_grant_cnt_o, 16'd5);
        checkOutput("sat_dcnt", d_grant_cnt_o, 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single burst-style main-memory port between the instruction-cache refill path and the data-cache refill/write-back path. Accepts block-granular read requests from the I-cache and read or write requests from the D-cache, grants one at a time with round-robin fairness, and forwards the winner to memory. It holds the grant until memory signals completion, then returns data and a one-cycle done pulse to the owner. It also keeps saturating per-requester grant counters for context-switch cache studies.

## Interface
- c_block_size, 2, log2 of words per block; block width BW = 2**c_block_size*c_line_size
- c_line_size, 32, bits per word
- address_size, 32, byte address width; block address width AW = address_size - c_block_size - 2
- m_clk_i  in  1  clock, rising edge
- m_reset_i  in  1  reset, asynchronous, active-high
- i_read_i  in  1  I-cache block read request (level, held until i_done_o)
- i_addr_i  in  AW  I-cache block address
- i_rdata_o  out  BW  block returned to I-cache, valid while i_done_o=1
- i_busywait_o  out  1  i_read_i & ~i_done_o
- i_done_o  out  1  one-cycle completion pulse
- d_read_i  in  1  D-cache block read request (level)
- d_write_i  in  1  D-cache block write request (level)
- d_addr_i  in  AW  D-cache block address
- d_wdata_i  in  BW  D-cache write block
- d_rdata_o  out  BW  block returned to D-cache, valid while d_done_o=1
- d_busywait_o  out  1  (d_read_i|d_write_i) & ~d_done_o
- d_done_o  out  1  one-cycle completion pulse
- mem_read_o  out  1  memory read request (level)
- mem_write_o  out  1  memory write request (level)
- mem_addr_o  out  AW  latched block address of current owner
- mem_wdata_o  out  BW  latched write block
- mem_rdata_i  in  BW  memory read block, valid when mem_done_i=1
- mem_busywait_i  in  1  memory busy (informational; not used for sequencing)
- mem_done_i  in  1  one-cycle memory completion pulse (read or write)
- i_grant_cnt_o  out  16  I-cache grants, saturating
- d_grant_cnt_o  out  16  D-cache grants, saturating

## Operation
- States: IDLE, SERVE_I, SERVE_D, RESP_I, RESP_D; registered state.
- IDLE: if exactly one requester asserts, grant it; if both, grant the one not granted last (last_grant register, reset value = I, so D wins first contention).
- On grant edge: latch address, write data and op (D: write if d_write_i, else read); update last_grant; increment owner's grant counter unless at 16'hFFFF.
- d_read_i and d_write_i both high is illegal; arbiter treats it as a write.
- SERVE_x: mem_read_o/mem_write_o driven from latched op; mem_addr_o/mem_wdata_o from latches; requester inputs ignored (changes do not affect the in-flight access). On mem_done_i: register mem_rdata_i into owner's rdata register, go to RESP_x.
- RESP_x: owner's done_o = 1, memory request deasserted; next state IDLE unconditionally.
- Requester drops its request on the edge ending its done_o cycle; a request still high in IDLE is treated as a new request.
- mem_done_i outside SERVE_x is ignored.
- Write completions return done_o; d_rdata_o is not updated on writes.

## Timing
- Reset (async): state IDLE, last_grant = I, all request/done/busywait-driving regs 0, mem_addr_o, mem_wdata_o, i_rdata_o, d_rdata_o = 0, counters 0. Reset mid-access aborts it; memory request drops immediately.
- Request seen at edge N (IDLE) -> mem_read_o/mem_write_o high from N to the edge that samples mem_done_i (edge M) -> done_o high for cycle M..M+1 -> IDLE at M+1. Total = memory latency + 2 cycles.
- Minimum gap between two memory requests: 1 cycle (RESP) + 1 cycle (IDLE arbitration).
- busywait outputs combinational from request inputs and done_o; no other combinational input-to-output paths.
- Counters saturate at 65535; no wrap.

## Test plan
- Reset mid-SERVE_D write: mem_write_o drops same cycle as m_reset_i; after release counters 0, mem_addr_o 0, state IDLE, next simultaneous request grants D.
- Lone I read addr 0x10, memory model returns 0x44443333_22221111_... after 4 cycles: mem_read_o high 4 cycles, i_done_o one pulse, i_rdata_o matches, i_grant_cnt_o=1, D outputs untouched.
- Simultaneous I read and D read from reset: D served first, then I; then both again: D, I order alternates (D,I,D,I), counters 2/2.
- D write addr 0x20 data pattern A while I holds request: mem_write_o with mem_wdata_o=A, d_done_o pulse, d_rdata_o unchanged, I granted 2 cycles after d_done_o.
- Requester changes d_addr_i during SERVE_D: mem_addr_o stays at latched value; stray mem_done_i in IDLE produces no done_o.
- Force i_grant_cnt_o to 65535 via 65535 I reads (or reduced sim): further grant leaves counter 65535.
